// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq; widths follow the float format parameters.
interface fp_addsub_seq_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, op_sub, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op_sub, op_a, op_b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract: flush-to-zero inputs, RNE rounding, {nv,of,uf,nx} flags,
// one operation in flight, fixed latency through UNPACK/ALIGN/ADD/NORM.
module fp_addsub_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input logic            clk,
    input logic            rst,
    fp_addsub_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int D  = FRAC_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(D + 1);
    localparam logic [EXP_W-1:0]  EXP_ALL   = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};
    localparam logic [XW-1:0]     EXP_ONES  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [XW-1:0]     SHIFT_MAX = XW'(D - 1);
    localparam logic [W-1:0]      QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_r, state_nx;

    logic [W-1:0]  a_r, b_r, spec_res_r, result_r;
    logic          sub_r, spec_r, sign_r, eff_sub_r, in_ready_r, out_valid_r;
    logic [3:0]    spec_flags_r, flags_r;
    logic [XW-1:0] exp_r, diff_r;
    logic [D-1:0]  big_r, small_r;

    logic [EXP_W-1:0]  ea_s, eb_s;
    logic [FRAC_W-1:0] fa_s, fb_s;
    logic sa_s, sb_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, a_ge_b_s;
    logic [D-1:0]  sig_a_s, sig_b_s;
    logic          spec_s;
    logic [W-1:0]  spec_res_s;
    logic [3:0]    spec_flags_s;
    logic [D-1:0]  small_al_s;
    logic [D:0]    sum_s;
    logic [D-1:0]  sum_n_s;
    logic [XW-1:0] exp_add_s;
    logic [LW-1:0] lz_s;
    logic [D-1:0]  norm_s;
    logic [XW-1:0] exp_n_s, exp_f_s;
    logic [FRAC_W:0] frac_inc_s;
    logic          round_up_s, nx_s;
    logic [W-1:0]  res_s;
    logic [3:0]    flags_s;

    // Leading-zero count; an all-zero word reports D.
    function automatic logic [LW-1:0] lzc(input logic [D-1:0] v);
        logic [LW-1:0] n;
        logic          found;
        n     = LW'(D);
        found = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LW'(D - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            in_ready_r  <= (state_nx == IDLE);
            out_valid_r <= (state_nx == DONE);
        end
    end

    // FSM next-state: fixed one-cycle pipeline states, DONE waits for the consumer.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_nx = UNPACK;
                else              state_nx = IDLE;
            end
            UNPACK: state_nx = ALIGN;
            ALIGN:  state_nx = ADD;
            ADD:    state_nx = NORM;
            NORM:   state_nx = DONE;
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
                else               state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand classification with subnormals flushed to signed zero.
    always_comb begin
        ea_s     = a_r[W-2 -: EXP_W];
        eb_s     = b_r[W-2 -: EXP_W];
        sa_s     = a_r[W-1];
        sb_s     = b_r[W-1] ^ sub_r;
        a_zero_s = (ea_s == EXP_ZERO);
        b_zero_s = (eb_s == EXP_ZERO);
        fa_s     = a_zero_s ? FRAC_ZERO : a_r[FRAC_W-1:0];
        fb_s     = b_zero_s ? FRAC_ZERO : b_r[FRAC_W-1:0];
        a_inf_s  = (ea_s == EXP_ALL) && (fa_s == FRAC_ZERO);
        b_inf_s  = (eb_s == EXP_ALL) && (fb_s == FRAC_ZERO);
        a_nan_s  = (ea_s == EXP_ALL) && (fa_s != FRAC_ZERO);
        b_nan_s  = (eb_s == EXP_ALL) && (fb_s != FRAC_ZERO);
        sig_a_s  = {~a_zero_s, fa_s, 3'b000};
        sig_b_s  = {~b_zero_s, fb_s, 3'b000};
        a_ge_b_s = (ea_s > eb_s) || ((ea_s == eb_s) && (fa_s >= fb_s));
    end

    // Special-value results, resolved early and carried to NORM.
    always_comb begin
        spec_s       = 1'b1;
        spec_res_s   = {W{1'b0}};
        spec_flags_s = 4'b0000;
        if (a_nan_s || b_nan_s) begin
            spec_res_s = QNAN;
        end else if (a_inf_s && b_inf_s) begin
            if (sa_s != sb_s) begin
                spec_res_s   = QNAN;
                spec_flags_s = 4'b1000;
            end else begin
                spec_res_s = {sa_s, EXP_ALL, FRAC_ZERO};
            end
        end else if (a_inf_s) begin
            spec_res_s = {sa_s, EXP_ALL, FRAC_ZERO};
        end else if (b_inf_s) begin
            spec_res_s = {sb_s, EXP_ALL, FRAC_ZERO};
        end else if (a_zero_s && b_zero_s) begin
            spec_res_s = {sa_s & sb_s, EXP_ZERO, FRAC_ZERO};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Alignment shift; everything shifted out collapses into the sticky bit.
    always_comb begin
        small_al_s = {D{1'b0}};
        if (diff_r >= SHIFT_MAX) begin
            small_al_s[0] = |small_r;
        end else begin
            small_al_s    = small_r >> diff_r;
            small_al_s[0] = small_al_s[0] | (|(small_r & ~({D{1'b1}} << diff_r)));
        end
    end

    // Magnitude add/subtract with carry-out renormalisation.
    always_comb begin
        sum_s = eff_sub_r ? ({1'b0, big_r} - {1'b0, small_r}) : ({1'b0, big_r} + {1'b0, small_r});
        if (sum_s[D]) begin
            sum_n_s   = {sum_s[D:2], sum_s[1] | sum_s[0]};
            exp_add_s = exp_r + {{(XW-1){1'b0}}, 1'b1};
        end else begin
            sum_n_s   = sum_s[D-1:0];
            exp_add_s = exp_r;
        end
    end

    // Normalise, round to nearest even, then classify overflow/underflow.
    always_comb begin
        lz_s       = lzc(big_r);
        norm_s     = big_r << lz_s;
        exp_n_s    = exp_r - XW'(lz_s);
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        nx_s       = |norm_s[2:0];
        frac_inc_s = {1'b0, norm_s[D-2:3]} + {{FRAC_W{1'b0}}, round_up_s};
        exp_f_s    = exp_n_s + {{(XW-1){1'b0}}, frac_inc_s[FRAC_W]};
        res_s      = {W{1'b0}};
        flags_s    = 4'b0000;
        if (spec_r) begin
            res_s   = spec_res_r;
            flags_s = spec_flags_r;
        end else if (!norm_s[D-1]) begin
            res_s = {W{1'b0}};
        end else if (exp_r <= XW'(lz_s)) begin
            res_s   = {sign_r, EXP_ZERO, FRAC_ZERO};
            flags_s = 4'b0011;
        end else if (exp_f_s >= EXP_ONES) begin
            res_s   = {sign_r, EXP_ALL, FRAC_ZERO};
            flags_s = 4'b0101;
        end else begin
            res_s   = {sign_r, exp_f_s[EXP_W-1:0], frac_inc_s[FRAC_W-1:0]};
            flags_s = {3'b000, nx_s};
        end
    end

    // Datapath registers; big_r is reused as the sum after ADD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= {W{1'b0}}; b_r <= {W{1'b0}}; sub_r <= 1'b0;
            spec_r <= 1'b0; spec_res_r <= {W{1'b0}}; spec_flags_r <= 4'b0000;
            sign_r <= 1'b0; eff_sub_r <= 1'b0;
            exp_r <= {XW{1'b0}}; diff_r <= {XW{1'b0}};
            big_r <= {D{1'b0}}; small_r <= {D{1'b0}};
            result_r <= {W{1'b0}}; flags_r <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.op_a;
                        b_r   <= bus.op_b;
                        sub_r <= bus.op_sub;
                    end
                end
                UNPACK: begin
                    spec_r       <= spec_s;
                    spec_res_r   <= spec_res_s;
                    spec_flags_r <= spec_flags_s;
                    eff_sub_r    <= sa_s ^ sb_s;
                    if (a_ge_b_s) begin
                        sign_r  <= sa_s;
                        exp_r   <= {2'b00, ea_s};
                        diff_r  <= {2'b00, ea_s} - {2'b00, eb_s};
                        big_r   <= sig_a_s;
                        small_r <= sig_b_s;
                    end else begin
                        sign_r  <= sb_s;
                        exp_r   <= {2'b00, eb_s};
                        diff_r  <= {2'b00, eb_s} - {2'b00, ea_s};
                        big_r   <= sig_b_s;
                        small_r <= sig_a_s;
                    end
                end
                ALIGN: small_r <= small_al_s;
                ADD: begin
                    big_r <= sum_n_s;
                    exp_r <= exp_add_s;
                end
                NORM: begin
                    result_r <= res_s;
                    flags_r  <= flags_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;
endmodule
